// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, state
// encoding and a constant-width helper.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_LAUNCH_ENC    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_LAUNCH    = ST_LAUNCH_ENC,
        ST_WAIT_DONE = ST_WAIT_DONE_ENC
    } arb_state_t;

    // Ceiling log2 for sizing index/counter fields; returns 0 for value <= 1.
    function automatic int uart_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: scans from the slot after the last
// grant upward with wrap and returns the first valid requester.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]             i_Valid,
    input  logic [uart_clog2(NUM_REQ)-1:0] i_Last,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic [uart_clog2(NUM_REQ)-1:0] o_Index,
    output logic                           o_Any
);

    localparam int IDX_W = uart_clog2(NUM_REQ);

    logic found;
    int   cand;

    // First valid slot at distance 1..NUM_REQ from the last grant; the last
    // grantee itself is checked last so it only wins when alone.
    always_comb begin
        o_Grant = '0;
        o_Index = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(i_Last) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && i_Valid[cand]) begin
                found         = 1'b1;
                o_Grant[cand] = 1'b1;
                o_Index       = IDX_W'(cand);
            end
        end
        o_Any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a single uart_tx serializer: accepts one byte
// per frame from NUM_REQ producers, launches it with a one-cycle DV pulse,
// then waits for the serializer's done (or a watchdog) before re-arbitrating.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic [NUM_REQ-1:0]             i_Req_Valid,
    input  logic [BYTE_W*NUM_REQ-1:0]      i_Req_Byte,
    output logic [NUM_REQ-1:0]             o_Req_Ready,
    output logic                           o_Tx_DV,
    output logic [BYTE_W-1:0]              o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic [uart_clog2(NUM_REQ)-1:0] o_Grant_Id,
    output logic                           o_Busy,
    output logic                           o_Timeout
);

    localparam int IDX_W = uart_clog2(NUM_REQ);
    localparam int CNT_W = uart_clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

    arb_state_t                          state;
    logic [IDX_W-1:0]                    last_grant;
    logic [CNT_W-1:0]                    wd_cnt;

    logic [NUM_REQ-1:0]                  pick_grant;
    logic [IDX_W-1:0]                    pick_idx;
    logic                                pick_any;
    logic [NUM_REQ-1:0][BYTE_W-1:0]      req_bytes;

    assign req_bytes = i_Req_Byte;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_Valid (i_Req_Valid),
        .i_Last  (last_grant),
        .o_Grant (pick_grant),
        .o_Index (pick_idx),
        .o_Any   (pick_any)
    );

    // Arbiter FSM with registered outputs; pointer resets to NUM_REQ-1 so
    // requester 0 is first in line. Pulses default low every cycle.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            last_grant  <= PTR_RESET;
            wd_cnt      <= '0;
            o_Req_Ready <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
            o_Grant_Id  <= '0;
            o_Busy      <= 1'b0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Req_Ready <= '0;
            o_Tx_DV     <= 1'b0;
            o_Timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Gate on i_Tx_Active so a frame left running across a
                    // reset is never stepped on.
                    if (pick_any && !i_Tx_Active) begin
                        o_Req_Ready <= pick_grant;
                        o_Tx_Byte   <= req_bytes[pick_idx];
                        o_Grant_Id  <= pick_idx;
                        last_grant  <= pick_idx;
                        o_Busy      <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    o_Tx_DV <= 1'b1;
                    wd_cnt  <= '0;
                    state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // Done has priority over a coincident watchdog expiry.
                    if (i_Tx_Done) begin
                        o_Busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (wd_cnt >= CNT_LAST) begin
                        o_Timeout <= 1'b1;
                        o_Busy    <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural serializer and
// line receiver, plus a round-robin queue model for expected grant order.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_byte  = '0;
    logic [3:0]  req_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    // serializer model (no reset, one clock per bit)
    logic        ser_busy = 1'b0;
    logic        ser_done = 1'b0;
    logic        tx_line  = 1'b1;
    logic [9:0]  ser_frame = '0;
    int          ser_idx = 0;
    logic        done_en = 1'b1;
    logic        force_done = 1'b0;

    // line receiver
    logic        rx_on = 1'b0;
    int          rx_n = 0;
    logic [7:0]  rx_sh = '0;
    logic [7:0]  rx_q[$];

    // bench bookkeeping
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          dv_cnt = 0;
    int          to_cnt = 0;
    logic        auto_mode = 1'b0;
    logic        ready_ser_busy = 1'b0;
    int          model_last = NR - 1;
    logic [7:0]  rq[4][$];
    int          glog_id[$];
    logic [7:0]  glog_byte[$];

    assign tx_active = ser_busy;
    assign tx_done   = (ser_done & done_en) | force_done;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .TIMEOUT_CLKS (TOUT)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .o_Req_Ready (req_ready),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Grant_Id  (grant_id),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ser_done <= 1'b0;
        if (!ser_busy) begin
            tx_line <= 1'b1;
            if (tx_dv) begin
                ser_busy  <= 1'b1;
                ser_frame <= {1'b1, tx_byte, 1'b0};
                ser_idx   <= 0;
            end
        end else if (ser_idx < 10) begin
            tx_line <= ser_frame[ser_idx];
            ser_idx <= ser_idx + 1;
        end else begin
            ser_done <= 1'b1;
            ser_busy <= 1'b0;
            tx_line  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rx_on) begin
            if (tx_line == 1'b0) begin
                rx_on = 1'b1;
                rx_n  = 0;
            end
        end else begin
            rx_sh[rx_n] = tx_line;
            rx_n = rx_n + 1;
            if (rx_n == 8) begin
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end
        end
    end

    // One cycle: sample outputs on the falling edge, log grants, and in
    // auto mode let each requester present the head of its byte queue.
    task automatic step();
        int id;
        int n;
        @(negedge clk);
        cyc++;
        if (tx_dv) dv_cnt++;
        if (timeout) to_cnt++;
        if (req_ready != '0) begin
            id = -1;
            n  = 0;
            for (int r = 0; r < NR; r++) if (req_ready[r]) begin n++; id = r; end
            checks++;
            if (n != 1) begin errors++; $display("FAIL ready_onehot got %b need one-hot", req_ready); end
            checks++;
            if (grant_id !== 2'(id)) begin errors++; $display("FAIL grant_id got %0d need %0d", grant_id, id); end
            glog_id.push_back(id);
            glog_byte.push_back(tx_byte);
            ready_ser_busy = ser_busy;
            if (auto_mode && rq[id].size() > 0) void'(rq[id].pop_front());
        end
        if (auto_mode) begin
            for (int r = 0; r < NR; r++) begin
                req_valid[r] = (rq[r].size() > 0);
                req_byte[8*r +: 8] = (rq[r].size() > 0) ? rq[r][0] : 8'h00;
            end
        end
    endtask

    task automatic do_reset();
        int g;
        g = 0;
        while (ser_busy && g < 200) begin step(); g++; end
        auto_mode = 1'b0; req_valid = '0; req_byte = '0;
        force_done = 1'b0; done_en = 1'b1;
        rst = 1'b1; step(); step(); rst = 1'b0; step();
        glog_id.delete(); glog_byte.delete(); rx_q.delete();
        for (int r = 0; r < NR; r++) rq[r].delete();
        model_last = NR - 1;
    endtask

    // Runs the bytes already loaded in rq with all pending requesters held
    // valid, and compares grant order, captured bytes and line bytes with a
    // round-robin model over the pending queues.
    task automatic run_batch(input string name);
        logic [7:0] data[4][$];
        int         exp_id[$];
        logic [7:0] exp_b[$];
        int         total, p, c, g, dv0;
        logic       hit;
        total = 0;
        for (int r = 0; r < NR; r++) begin
            data[r] = rq[r];
            total += rq[r].size();
        end
        p = model_last;
        for (int n = 0; n < total; n++) begin
            hit = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                c = (p + k) % NR;
                if (!hit && data[c].size() > 0) begin
                    hit = 1'b1;
                    exp_id.push_back(c);
                    exp_b.push_back(data[c].pop_front());
                    p = c;
                end
            end
        end
        model_last = p;
        glog_id.delete(); glog_byte.delete(); rx_q.delete();
        dv0 = dv_cnt;
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = (rq[r].size() > 0);
            req_byte[8*r +: 8] = (rq[r].size() > 0) ? rq[r][0] : 8'h00;
        end
        auto_mode = 1'b1;
        g = 0;
        while (!(glog_id.size() >= total && rx_q.size() >= total && !busy && !ser_busy) && g < 100 * total + 100) begin
            step(); g++;
        end
        auto_mode = 1'b0; req_valid = '0;
        checks++;
        if (glog_id.size() != total || rx_q.size() != total) begin
            errors++;
            $display("FAIL %s_count got grants %0d frames %0d need %0d", name, glog_id.size(), rx_q.size(), total);
        end
        checks++;
        if (dv_cnt - dv0 != total) begin errors++; $display("FAIL %s_dv got %0d need %0d", name, dv_cnt - dv0, total); end
        for (int i = 0; i < total; i++) begin
            if (i < glog_id.size()) begin
                checks++;
                if (glog_id[i] != exp_id[i]) begin errors++; $display("FAIL %s_id[%0d] got %0d need %0d", name, i, glog_id[i], exp_id[i]); end
                checks++;
                if (glog_byte[i] !== exp_b[i]) begin errors++; $display("FAIL %s_byte[%0d] got %h need %h", name, i, glog_byte[i], exp_b[i]); end
            end
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== exp_b[i]) begin errors++; $display("FAIL %s_line[%0d] got %h need %h", name, i, rx_q[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        checks++;
        if ({req_ready, tx_dv, tx_byte, grant_id, busy, timeout} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b dv=%b byte=%h id=%0d busy=%b to=%b need all 0",
                     req_ready, tx_dv, tx_byte, grant_id, busy, timeout);
        end
        rst = 1'b0; step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b need 0", busy); end
    endtask

    task automatic test_single();
        int g, dv0;
        do_reset();
        dv0 = dv_cnt;
        req_valid[2] = 1'b1; req_byte[23:16] = 8'hAB;
        g = 0;
        while (glog_id.size() == 0 && g < 20) begin step(); g++; end
        req_valid = '0;
        checks++;
        if (glog_id.size() != 1 || glog_id[0] != 2 || glog_byte[0] !== 8'hAB)
            begin errors++; $display("FAIL single_grant got n=%0d need one grant of 2 with ab", glog_id.size()); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b need 1", busy); end
        step();
        checks++;
        if (tx_dv !== 1'b1) begin errors++; $display("FAIL single_dv_hi got %b need 1", tx_dv); end
        step();
        checks++;
        if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_dv_lo got %b need 0", tx_dv); end
        g = 0;
        while ((rx_q.size() == 0 || busy) && g < 100) begin step(); g++; end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAB) begin errors++; $display("FAIL single_line got %0d frames need one ab", rx_q.size()); end
        checks++;
        if (dv_cnt - dv0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL single_end got dv=%0d busy=%b need 1 0", dv_cnt - dv0, busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rq[0].push_back(8'h11); rq[0].push_back(8'h55);
        rq[1].push_back(8'h22); rq[1].push_back(8'h66);
        rq[2].push_back(8'h33);
        rq[3].push_back(8'h44);
        run_batch("b2b");
        checks++;
        if (glog_id.size() < 5 || glog_id[0] != 0 || glog_id[3] != 3 || glog_id[4] != 0)
            begin errors++; $display("FAIL b2b_order got %0d grants need 0,1,2,3,0,..", glog_id.size()); end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < NR; r++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) rq[r].push_back(8'($urandom_range(0, 255)));
            end
            if (rq[0].size() == 0) rq[0].push_back(8'($urandom_range(0, 255)));
            run_batch("rand");
        end
    endtask

    task automatic test_skip_drop();
        int g;
        do_reset();
        rq[1].push_back(8'($urandom_range(0, 255)));
        rq[3].push_back(8'($urandom_range(0, 255)));
        run_batch("skip");
        checks++;
        if (glog_id.size() != 2 || glog_id[0] != 1) begin errors++; $display("FAIL skip_first got n=%0d need grants 1 then 3", glog_id.size()); end
        do_reset();
        req_valid[0] = 1'b1; req_byte[7:0]  = 8'h5A;
        req_valid[1] = 1'b1; req_byte[15:8] = 8'hC3;
        g = 0;
        while (glog_id.size() == 0 && g < 20) begin step(); g++; end
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_valid[3] = 1'b1; req_byte[31:24] = 8'h7E;
        g = 0;
        while (glog_id.size() < 2 && g < 100) begin step(); g++; end
        req_valid = '0;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (glog_id.size() != 2 || glog_id[0] != 0 || glog_id[1] != 3)
            begin errors++; $display("FAIL drop_order got n=%0d need grants 0 then 3 only", glog_id.size()); end
    endtask

    task automatic test_timeout();
        int g, t0, to0;
        do_reset();
        done_en = 1'b0;
        to0 = to_cnt;
        req_valid[2] = 1'b1; req_byte[23:16] = 8'h3C;
        g = 0;
        while (glog_id.size() == 0 && g < 20) begin step(); g++; end
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1; req_byte[7:0] = 8'hE1;
        g = 0;
        while (!tx_dv && g < 20) begin step(); g++; end
        t0 = cyc;
        g = 0;
        while (!timeout && g < 60) begin step(); g++; end
        checks++;
        if (!timeout || cyc - t0 != TOUT) begin errors++; $display("FAIL timeout_delay got %0d need %0d", cyc - t0, TOUT); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b need 0", busy); end
        step();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b need 0", timeout); end
        g = 0;
        while (glog_id.size() < 2 && g < 20) begin step(); g++; end
        req_valid = '0;
        checks++;
        if (glog_id.size() != 2 || glog_id[1] != 0) begin errors++; $display("FAIL timeout_next got n=%0d need grant 0", glog_id.size()); end
        done_en = 1'b1;
        g = 0;
        while ((busy || ser_busy) && g < 100) begin step(); g++; end
        checks++;
        if (to_cnt - to0 != 1) begin errors++; $display("FAIL timeout_count got %0d need 1", to_cnt - to0); end
    endtask

    task automatic test_done_vs_timeout();
        int g, to0;
        do_reset();
        done_en = 1'b0;
        to0 = to_cnt;
        req_valid[1] = 1'b1; req_byte[15:8] = 8'h96;
        g = 0;
        while (glog_id.size() == 0 && g < 20) begin step(); g++; end
        req_valid = '0;
        g = 0;
        while (!tx_dv && g < 20) begin step(); g++; end
        for (int i = 0; i < TOUT - 1; i++) step();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_wins got to=%b busy=%b need 0 0", timeout, busy); end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (to_cnt - to0 != 0) begin errors++; $display("FAIL done_wins_count got %0d need 0", to_cnt - to0); end
    endtask

    task automatic test_midframe_reset();
        int         g, dv0;
        logic [7:0] b;
        do_reset();
        b = 8'($urandom_range(0, 255)) | 8'h01;
        req_valid[0] = 1'b1; req_byte[7:0] = b;
        g = 0;
        while (!tx_dv && g < 20) begin step(); g++; end
        step(); step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, tx_dv, tx_byte, grant_id, busy, timeout} !== 17'h0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b dv=%b byte=%h id=%0d busy=%b need all 0",
                     req_ready, tx_dv, tx_byte, grant_id, busy);
        end
        step();
        rst = 1'b0;
        glog_id.delete(); glog_byte.delete();
        dv0 = dv_cnt;
        g = 0;
        while (glog_id.size() == 0 && g < 60) begin step(); g++; end
        checks++;
        if (glog_id.size() != 1 || glog_id[0] != 0 || glog_byte[0] !== b)
            begin errors++; $display("FAIL midreset_regrant got n=%0d need grant 0 byte %h", glog_id.size(), b); end
        checks++;
        if (ready_ser_busy !== 1'b0 || dv_cnt != dv0) begin
            errors++;
            $display("FAIL midreset_gate got ser_busy=%b dv=%0d need 0 0", ready_ser_busy, dv_cnt - dv0);
        end
        req_valid = '0;
        g = 0;
        while ((busy || ser_busy) && g < 100) begin step(); g++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_skip_drop();
        test_timeout();
        test_done_vs_timeout();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer between `NUM_REQ` byte producers. Sits directly in front of `uart_tx`: it collects valid/ready byte requests, selects one round-robin, issues the single-cycle `i_Tx_DV` launch, and holds off further grants until the serializer reports `o_Tx_Done`. A watchdog recovers the arbiter if `o_Tx_Done` never arrives.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CLKS`, 2048: max cycles in WAIT_DONE before forced recovery; must exceed 10*CLKS_PER_BIT+4.
- `i_Clock`  in  1  system clock, all logic on rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Req_Valid`  in  NUM_REQ  per-requester byte valid.
- `i_Req_Byte`  in  8*NUM_REQ  requester r byte on bits [8r+7:8r].
- `o_Req_Ready`  out  NUM_REQ  one-cycle accept pulse, one-hot.
- `o_Tx_DV`  out  1  to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte`  out  8  to `uart_tx` `i_Tx_Byte`.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`.
- `o_Grant_Id`  out  clog2(NUM_REQ)  index of current/last granted requester.
- `o_Busy`  out  1  high in LAUNCH and WAIT_DONE.
- `o_Timeout`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- All outputs registered. Reset values: `o_Req_Ready`=0, `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Grant_Id`=0, `o_Busy`=0, `o_Timeout`=0; state IDLE; last-grant pointer = NUM_REQ-1 (requester 0 highest priority first).
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE: if any `i_Req_Valid` and `i_Tx_Active`=0, pick first valid requester scanning from (last_grant+1) mod NUM_REQ upward with wrap; capture its byte into `o_Tx_Byte`, pulse its `o_Req_Ready`, update `o_Grant_Id` and last_grant, go LAUNCH. No valid, or `i_Tx_Active`=1: stay.
- LAUNCH: `o_Tx_DV`=1 for exactly this cycle; clear watchdog counter; go WAIT_DONE.
- WAIT_DONE: `i_Tx_Done`=1 -> IDLE. Else counter increments; counter reaching TIMEOUT_CLKS-1 -> pulse `o_Timeout`, go IDLE. Counter width clog2(TIMEOUT_CLKS+1), never wraps.
- Requester rule: hold valid and byte stable until ready seen; may drop valid at any time before grant (no lock-in); valid held after ready = next byte.
- Only valids in IDLE are sampled; requests during LAUNCH/WAIT_DONE wait.

## Timing
- Valid sampled at edge E (IDLE) -> `o_Req_Ready` and `o_Tx_Byte` valid after E; `o_Tx_DV` high after E+1 for one cycle; `o_Tx_Byte` stable from E until next grant.
- `i_Tx_Done` sampled at edge D -> IDLE after D; next grant earliest at D+1, so back-to-back frames cost 2 idle cycles plus `uart_tx` cleanup.
- `i_Tx_Done` in IDLE or LAUNCH: ignored.
- Simultaneous done and watchdog expiry: done wins, no `o_Timeout`.
- Reset mid-frame: arbiter returns to IDLE immediately; `uart_tx` (no reset) finishes its frame; the `i_Tx_Active` gate prevents a launch until it completes.

## Structure
- Package `uart_pkg`: state encoding localparams, byte width 8, clog2 helper.
- Sub-module `uart_rr_picker`: combinational round-robin one-hot picker (valid vector, last-grant pointer -> one-hot grant, index, any-valid). Arbiter holds FSM, pointer, watchdog.

## Test plan
- Reset, NUM_REQ=4, single req 2 valid with 8'hAB, real `uart_tx` at CLKS_PER_BIT=2 -> one ready pulse on bit 2, one `o_Tx_DV` pulse, line carries 0xAB, `o_Busy` drops after done.
- All four valid continuously (0x11,0x22,0x33,0x44) -> grants 0,1,2,3,0 in order, one ready per frame, bytes serialized in that order.
- Req 1 and 3 valid, last grant 3 -> grant 1 next, then 3; req 1 drops valid before its turn -> never granted.
- Stub `uart_tx`, `i_Tx_Done` never pulsed, TIMEOUT_CLKS=16 -> `o_Timeout` pulses 16 cycles after LAUNCH, pending request then granted.
- Done pulse coinciding with watchdog last count -> no `o_Timeout`, normal return to IDLE.
- Assert `i_Reset` mid-frame with req 0 still valid -> outputs at reset values; no `o_Tx_DV` until `i_Tx_Active` falls; req 0 then granted.
